// File: rtl/ch_fifo_pkg.sv
// Shared width helpers for the ch_fifo queue and its pointer counters.
package ch_fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Pointer width never collapses to zero bits, even for tiny depths.
  function automatic int ptr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ch_fifo_ptr.sv
// Modulo-DEPTH wrap counter used for the FIFO head and tail pointers.
// Wraps explicitly at DEPTH-1 so non-power-of-two depths work; clr wins over inc.
module ch_fifo_ptr
  import ch_fifo_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ch_fifo.sv
// Parametrised ready/valid FIFO with flush, occupancy and almost-full/empty flags.
// One-cycle write-to-read latency, no bypass; a full FIFO refuses enq even if deq fires.
module ch_fifo
  import ch_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int DEPTH        = 2,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1,
  localparam int PW          = ptr_w(DEPTH),
  localparam int CW          = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_flush,
  input  logic                  io_enq_valid,
  input  logic [DATA_WIDTH-1:0] io_enq_data,
  output logic                  io_enq_ready,
  input  logic                  io_deq_ready,
  output logic                  io_deq_valid,
  output logic [DATA_WIDTH-1:0] io_deq_data,
  output logic [CW-1:0]         io_size,
  output logic                  io_almost_full,
  output logic                  io_almost_empty
);

  if (DEPTH < 2 || AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH ||
      AEMPTY_LEVEL < 0 || AEMPTY_LEVEL >= DEPTH) begin : g_param_check
    $error("ch_fifo: illegal DEPTH/AFULL_LEVEL/AEMPTY_LEVEL combination");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  enq_fire;
  logic                  deq_fire;

  // Flush masks both handshakes so nothing completes in the flush cycle.
  assign io_enq_ready = (count_q != CW'(DEPTH)) & ~io_flush;
  assign io_deq_valid = (count_q != '0) & ~io_flush;
  assign enq_fire     = io_enq_valid & io_enq_ready;
  assign deq_fire     = io_deq_valid & io_deq_ready;

  always_comb begin
    count_d = count_q;
    if (io_flush) begin
      count_d = '0;
    end else if (enq_fire && !deq_fire) begin
      count_d = count_q + CW'(1);
    end else if (deq_fire && !enq_fire) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  ch_fifo_ptr #(.DEPTH(DEPTH)) u_head (
    .clk   (clk),
    .reset (reset),
    .inc   (deq_fire),
    .clr   (io_flush),
    .ptr   (head)
  );

  ch_fifo_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk   (clk),
    .reset (reset),
    .inc   (enq_fire),
    .clr   (io_flush),
    .ptr   (tail)
  );

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem_q[tail] <= io_enq_data;
    end
  end

  assign io_deq_data     = mem_q[head];
  assign io_size         = count_q;
  assign io_almost_full  = (count_q >= CW'(AFULL_LEVEL));
  assign io_almost_empty = (count_q <= CW'(AEMPTY_LEVEL));

endmodule

// File: tb/tb_ch_fifo.sv
// Bench for ch_fifo (DEPTH=5, W=8): directed scenarios plus random traffic,
// checked by a negedge monitor against a queue-based reference model.
module tb_ch_fifo;

  localparam int W     = 8;
  localparam int D     = 5;
  localparam int AFULL = 4;
  localparam int AEMPT = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         io_flush = 1'b0;
  logic         io_enq_valid = 1'b0;
  logic [W-1:0] io_enq_data = '0;
  logic         io_enq_ready;
  logic         io_deq_ready = 1'b0;
  logic         io_deq_valid;
  logic [W-1:0] io_deq_data;
  logic [2:0]   io_size;
  logic         io_almost_full;
  logic         io_almost_empty;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] model_q [$];

  ch_fifo #(
    .DATA_WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AFULL), .AEMPTY_LEVEL(AEMPT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .io_flush        (io_flush),
    .io_enq_valid    (io_enq_valid),
    .io_enq_data     (io_enq_data),
    .io_enq_ready    (io_enq_ready),
    .io_deq_ready    (io_deq_ready),
    .io_deq_valid    (io_deq_valid),
    .io_deq_data     (io_deq_data),
    .io_size         (io_size),
    .io_almost_full  (io_almost_full),
    .io_almost_empty (io_almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every output against the model, then apply this cycle's handshakes.
  always @(negedge clk) begin
    int sz;
    logic [W-1:0] exp_d;
    if (!reset) model_q.delete();
    sz = model_q.size();
    chk("size", 32'(io_size), 32'(sz));
    chk("enq_ready", 32'(io_enq_ready), 32'(sz < D && !io_flush));
    chk("deq_valid", 32'(io_deq_valid), 32'(sz > 0 && !io_flush));
    chk("almost_full", 32'(io_almost_full), 32'(sz >= AFULL));
    chk("almost_empty", 32'(io_almost_empty), 32'(sz <= AEMPT));
    if (reset) begin
      if (io_flush) begin
        model_q.delete();
      end else begin
        if (sz > 0 && io_deq_ready) begin
          exp_d = model_q.pop_front();
          chk("deq_data", 32'(io_deq_data), 32'(exp_d));
        end
        if (sz < D && io_enq_valid) model_q.push_back(io_enq_data);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b0;
    io_flush     = 1'b0;
  endtask

  initial begin
    // Reset values while reset is held
    #2;
    chk("rst_size", 32'(io_size), 32'd0);
    chk("rst_enq_ready", 32'(io_enq_ready), 32'd1);
    chk("rst_deq_valid", 32'(io_deq_valid), 32'd0);
    chk("rst_afull", 32'(io_almost_full), 32'd0);
    chk("rst_aempty", 32'(io_almost_empty), 32'd1);
    cyc(2);
    reset = 1'b1;
    cyc();

    // Fill 0x11..0x15
    for (int i = 0; i < D; i++) begin
      io_enq_valid = 1'b1;
      io_enq_data  = W'(8'h11 + i);
      cyc();
      chk("fill_size", 32'(io_size), 32'(i + 1));
    end
    io_enq_valid = 1'b0;
    chk("full_enq_ready", 32'(io_enq_ready), 32'd0);
    chk("full_afull", 32'(io_almost_full), 32'd1);

    // Full with deq_ready: only the dequeue fires
    io_enq_valid = 1'b1;
    io_enq_data  = 8'h99;
    io_deq_ready = 1'b1;
    cyc();
    idle();
    chk("full_deq_size", 32'(io_size), 32'd4);
    chk("full_deq_enq_ready", 32'(io_enq_ready), 32'd1);

    // Drain remaining four
    io_deq_ready = 1'b1;
    cyc(4);
    idle();
    chk("drain_valid", 32'(io_deq_valid), 32'd0);
    chk("drain_aempty", 32'(io_almost_empty), 32'd1);

    // Wrap-around: hold count at 2 with simultaneous enq/deq
    io_enq_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      io_enq_data = W'(8'h30 + i);
      cyc();
    end
    io_deq_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      io_enq_data = W'(8'h40 + i);
      cyc();
      chk("wrap_size", 32'(io_size), 32'd2);
    end
    idle();

    // Flush at count 3 with a pending enqueue
    io_deq_ready = 1'b1;
    cyc(2);
    idle();
    io_enq_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      io_enq_data = W'(8'h50 + i);
      cyc();
    end
    io_flush    = 1'b1;
    io_enq_data = 8'hEE;
    #1;
    chk("flush_enq_ready", 32'(io_enq_ready), 32'd0);
    chk("flush_deq_valid", 32'(io_deq_valid), 32'd0);
    cyc();
    io_flush = 1'b0;
    io_enq_valid = 1'b0;
    chk("flush_size", 32'(io_size), 32'd0);
    io_enq_valid = 1'b1;
    io_enq_data  = 8'hA5;
    cyc();
    idle();
    chk("post_flush_data", 32'(io_deq_data), 32'h0A5);
    io_deq_ready = 1'b1;
    cyc();
    idle();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      io_enq_valid = 1'($urandom_range(0, 1));
      io_deq_ready = 1'($urandom_range(0, 2) != 0 ? (i / 200) % 2 : 1);
      io_enq_data  = W'($urandom);
      io_flush     = ($urandom_range(0, 59) == 0);
      cyc();
    end
    idle();

    // Async reset at count 3, checked between edges
    io_flush = 1'b1;
    cyc();
    io_flush = 1'b0;
    io_enq_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      io_enq_data = W'(8'h60 + i);
      cyc();
    end
    idle();
    chk("pre_rst_size", 32'(io_size), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_size", 32'(io_size), 32'd0);
    chk("async_rst_valid", 32'(io_deq_valid), 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
